coherence_bus_ctrl: RTL and testbench
=====================================

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1: system clock; all state updates on posedge.
REQ-002 SHALL have port nRST, input, 1: asynchronous active-low reset.
REQ-003 SHALL have ports iREN[1:0], dREN[1:0], dWEN[1:0], cctrans[1:0], ccwrite[1:0], inputs, 1 per core: cache requests and coherence controls.
REQ-004 SHALL have ports iaddr[2], daddr[2], dstore[2], inputs, 32 each: per-core addresses and store data.
REQ-005 SHALL have ports iwait[1:0], dwait[1:0], outputs, 1 per core: 0 = word completes this cycle.
REQ-006 SHALL have ports iload[2], dload[2], outputs, 32 each: returned words.
REQ-007 SHALL have ports ccwait[1:0], ccinv[1:0], outputs, 1 per core; ccsnoopaddr[2], outputs, 32 each: snoop controls.
REQ-008 SHALL have ports ramaddr (32), ramstore (32), ramREN (1), ramWEN (1), outputs; ramload (32), ramstate (2: FREE=0, BUSY=1, ACCESS=2, ERROR=3), inputs.

Function
REQ-009 SHALL implement states IDLE, MEMWR, SNOOP, C2C1, C2C2, RAMRD1, RAMRD2, IFETCH.
REQ-010 SHALL default every cycle to iwait=dwait=2'b11, ccwait=ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, loads=0.
REQ-011 SHALL in IDLE grant data requests (dREN|dWEN) before instruction requests; ties between cores resolved by 1-bit round-robin pointer ptr (granted core = ptr when both request).
REQ-012 SHALL latch granted requester r and snooper s=~r on leaving IDLE; ptr <= ~r on every grant completion (return to IDLE).
REQ-013 SHALL on grant with dWEN[r] go MEMWR: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]; dwait[r]=0 and next IDLE when ramstate==ACCESS.
REQ-014 SHALL on grant with dREN[r]&cctrans[r] go SNOOP; dREN[r] without cctrans[r] goes RAMRD1 directly.
REQ-015 SHALL in SNOOP, C2C1, C2C2 assert ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r] (latched at grant).
REQ-016 SHALL leave SNOOP after exactly one cycle: cctrans[s]=1 -> C2C1, else -> RAMRD1.
REQ-017 SHALL in C2C1/C2C2 forward dload[r]=dstore[s] and write it to RAM (ramWEN=1, ramaddr=daddr[s]); on ACCESS assert dwait[r]=dwait[s]=0 and advance C2C1->C2C2->IDLE.
REQ-018 SHALL in RAMRD1/RAMRD2 drive ramREN=1, ramaddr=daddr[r], dload[r]=ramload; on ACCESS dwait[r]=0 and advance RAMRD1->RAMRD2->IDLE.
REQ-019 SHALL on instruction grant go IFETCH: ramREN=1, ramaddr=iaddr[r], iload[r]=ramload; on ACCESS iwait[r]=0, next IDLE.
REQ-020 SHALL hold state on ramstate FREE/BUSY/ERROR (no wait deasserted).
REQ-021 SHALL never assert ramREN and ramWEN together; iwait of a core never drops in a data state.
REQ-022 SHALL return to IDLE if requester drops its request mid-transaction (dREN[r]=dWEN[r]=0 in a data state, or iREN[r]=0 in IFETCH), with no wait deasserted that cycle.
REQ-023 SHALL ignore cctrans from a core not currently snooped or granted.

Reset
REQ-024 SHALL on nRST=0 immediately force state=IDLE, ptr=0, r=0, latched ccinv=0; outputs take REQ-010 defaults.
REQ-025 SHALL abandon any in-flight transaction on reset mid-operation, issuing no further RAM strobes.

Verification
REQ-026 Both cores dREN+cctrans same cycle after reset, core1 cctrans=0 in SNOOP, RAM ACCESS every cycle -> core0 served first (RAMRD1, RAMRD2), then core1; ptr alternates.
REQ-027 Core0 dREN+cctrans+ccwrite=1 addr 0x100, core1 replies cctrans=1, dstore=0xDEADBEEF -> ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x100, dload[0]=0xDEADBEEF, RAM write of 0xDEADBEEF.
REQ-028 Core1 dWEN addr 0x3100 data 0x5, ramstate BUSY 3 cycles then ACCESS -> ramWEN held 4 cycles, dwait[1]=0 only on 4th.
REQ-029 Core0 iREN and core1 dREN same cycle -> core1 data served before core0 IFETCH.
REQ-030 nRST asserted during C2C1 -> next cycle all ccwait=0, dwait=iwait=2'b11, ramWEN=0, state IDLE.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Two-core coherence bus controller: arbitrates I/D cache requests onto one RAM port,
// snooping the other core on coherent reads and forwarding its dirty data cache-to-cache.
module coherence_bus_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  iREN,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  input  logic [31:0] iaddr [2],
  input  logic [31:0] daddr [2],
  input  logic [31:0] dstore [2],
  output logic [1:0]  iwait,
  output logic [1:0]  dwait,
  output logic [31:0] iload [2],
  output logic [31:0] dload [2],
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr [2],
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [2:0] {
    IDLE, MEMWR, SNOOP, C2C1, C2C2, RAMRD1, RAMRD2, IFETCH
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   r_q, r_d;
  logic   inv_q, inv_d;
  logic   s;
  logic   gnt;
  logic   access;
  logic   data_held;
  logic [1:0] dreq;

  assign s         = ~r_q;
  assign access    = (ramstate == RAM_ACCESS);
  assign data_held = dREN[r_q] | dWEN[r_q];
  assign dreq      = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      r_q     <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      r_q     <= r_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    r_d     = r_q;
    inv_d   = inv_q;
    gnt     = ptr_q;
    case (state_q)
      IDLE: begin
        // Data traffic always wins over instruction fetches; ptr only breaks same-class ties.
        if (|dreq) begin
          gnt   = (&dreq) ? ptr_q : dreq[1];
          r_d   = gnt;
          inv_d = ccwrite[gnt];
          if (dWEN[gnt])         state_d = MEMWR;
          else if (cctrans[gnt]) state_d = SNOOP;
          else                   state_d = RAMRD1;
        end else if (|iREN) begin
          gnt     = (&iREN) ? ptr_q : iREN[1];
          r_d     = gnt;
          inv_d   = 1'b0;
          state_d = IFETCH;
        end
      end
      MEMWR:  if (!data_held || access) state_d = IDLE;
      SNOOP: begin
        if (!data_held)      state_d = IDLE;
        else if (cctrans[s]) state_d = C2C1;
        else                 state_d = RAMRD1;
      end
      C2C1:   if (!data_held) state_d = IDLE; else if (access) state_d = C2C2;
      C2C2:   if (!data_held || access) state_d = IDLE;
      RAMRD1: if (!data_held) state_d = IDLE; else if (access) state_d = RAMRD2;
      RAMRD2: if (!data_held || access) state_d = IDLE;
      IFETCH: if (!iREN[r_q] || access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d == IDLE) ptr_d = ~r_q;
  end

  always_comb begin
    iwait          = 2'b11;
    dwait          = 2'b11;
    ccwait         = 2'b00;
    ccinv          = 2'b00;
    ccsnoopaddr[0] = '0;
    ccsnoopaddr[1] = '0;
    iload[0]       = '0;
    iload[1]       = '0;
    dload[0]       = '0;
    dload[1]       = '0;
    ramaddr        = '0;
    ramstore       = '0;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    // A requester that drops its request gets nothing more: outputs stay at defaults.
    case (state_q)
      MEMWR: if (data_held) begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_q];
        ramstore = dstore[r_q];
        if (access) dwait[r_q] = 1'b0;
      end
      SNOOP: if (data_held) begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = inv_q;
        ccsnoopaddr[s] = daddr[r_q];
      end
      C2C1, C2C2: if (data_held) begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = inv_q;
        ccsnoopaddr[s] = daddr[r_q];
        dload[r_q]     = dstore[s];
        ramWEN         = 1'b1;
        ramaddr        = daddr[s];
        ramstore       = dstore[s];
        if (access) begin
          dwait[r_q] = 1'b0;
          dwait[s]   = 1'b0;
        end
      end
      RAMRD1, RAMRD2: if (data_held) begin
        ramREN     = 1'b1;
        ramaddr    = daddr[r_q];
        dload[r_q] = ramload;
        if (access) dwait[r_q] = 1'b0;
      end
      IFETCH: if (iREN[r_q]) begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[r_q];
        iload[r_q] = ramload;
        if (access) iwait[r_q] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: arbitration order, snoop/cache-to-cache
// forwarding, busy RAM writes, request drop and mid-transaction reset.
module tb_coherence_bus_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  logic [31:0] iaddr [2];
  logic [31:0] daddr [2];
  logic [31:0] dstore [2];
  logic [1:0]  iwait, dwait;
  logic [31:0] iload [2];
  logic [31:0] dload [2];
  logic [1:0]  ccwait, ccinv;
  logic [31:0] ccsnoopaddr [2];
  logic [31:0] ramaddr, ramstore;
  logic        ramREN, ramWEN;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  coherence_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr[0] = '0; iaddr[1] = '0; daddr[0] = '0; daddr[1] = '0;
    dstore[0] = '0; dstore[1] = '0;
    ramload = '0; ramstate = FREE;
    repeat (2) cyc();
    #1;
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ccwait", ccwait, 2'b00);
    check("rst_ccinv", ccinv, 2'b00);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    nRST = 1'b1;

    // Both cores coherent-read; core0 wins first (ptr=0), core1 second
    ramstate = ACCESS; dREN = 2'b11; cctrans = 2'b11;
    daddr[0] = 32'h40; daddr[1] = 32'h80; ramload = 32'h1111;
    #1 check("idle_ramREN", ramREN, 1'b0);
    cyc();
    cctrans = 2'b01;
    #1;
    check("s0_ccwait", ccwait, 2'b10);
    check("s0_snoopaddr1", ccsnoopaddr[1], 32'h40);
    check("s0_dwait", dwait, 2'b11);
    cyc();
    #1;
    check("rd0a_ramREN", ramREN, 1'b1);
    check("rd0a_ramWEN", ramWEN, 1'b0);
    check("rd0a_ramaddr", ramaddr, 32'h40);
    check("rd0a_dwait", dwait, 2'b10);
    check("rd0a_dload0", dload[0], 32'h1111);
    cyc();
    ramload = 32'h2222; cctrans = 2'b00;
    #1;
    check("rd0b_dload0", dload[0], 32'h2222);
    check("rd0b_dwait", dwait, 2'b10);
    cyc();
    #1 check("idle2_dwait", dwait, 2'b11);
    cyc();
    #1;
    check("rd1a_ramaddr", ramaddr, 32'h80);
    check("rd1a_dwait", dwait, 2'b01);
    cyc();
    #1 check("rd1b_dwait", dwait, 2'b01);
    cyc();
    dREN = 2'b00;
    #1 check("idle3_ramREN", ramREN, 1'b0);
    cyc();

    // Cache-to-cache: core0 coherent write-miss, core1 supplies dirty data
    dREN = 2'b01; cctrans = 2'b11; ccwrite = 2'b01;
    daddr[0] = 32'h100; daddr[1] = 32'h200; dstore[1] = 32'hDEADBEEF;
    cyc();
    ccwrite = 2'b00;
    #1;
    check("c2c_snoop_ccwait", ccwait, 2'b10);
    check("c2c_snoop_ccinv", ccinv, 2'b10);
    check("c2c_snoop_addr1", ccsnoopaddr[1], 32'h100);
    check("c2c_snoop_addr0", ccsnoopaddr[0], 32'h0);
    cyc();
    #1;
    check("c2c1_dload0", dload[0], 32'hDEADBEEF);
    check("c2c1_ramWEN", ramWEN, 1'b1);
    check("c2c1_ramREN", ramREN, 1'b0);
    check("c2c1_ramstore", ramstore, 32'hDEADBEEF);
    check("c2c1_ramaddr", ramaddr, 32'h200);
    check("c2c1_dwait", dwait, 2'b00);
    check("c2c1_ccinv", ccinv, 2'b10);
    check("c2c1_iwait", iwait, 2'b11);
    cyc();
    #1 check("c2c2_dwait", dwait, 2'b00);
    cyc();
    dREN = 2'b00; cctrans = 2'b00;
    #1 check("c2c_idle_ccwait", ccwait, 2'b00);

    // Core1 write with RAM busy for three cycles
    dWEN = 2'b10; daddr[1] = 32'h3100; dstore[1] = 32'h5; ramstate = BUSY;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wr_busy%0d_ramWEN", i), ramWEN, 1'b1);
      check($sformatf("wr_busy%0d_dwait", i), dwait, 2'b11);
      cyc();
    end
    ramstate = ACCESS;
    #1;
    check("wr_acc_ramWEN", ramWEN, 1'b1);
    check("wr_acc_ramaddr", ramaddr, 32'h3100);
    check("wr_acc_ramstore", ramstore, 32'h5);
    check("wr_acc_dwait", dwait, 2'b01);
    cyc();
    dWEN = 2'b00;
    #1 check("wr_idle_ramWEN", ramWEN, 1'b0);

    // Core0 ifetch vs core1 data read: data first
    iREN = 2'b01; iaddr[0] = 32'h500; dREN = 2'b10; daddr[1] = 32'h600; ramload = 32'h3333;
    cyc();
    #1;
    check("pri_rd_ramaddr", ramaddr, 32'h600);
    check("pri_rd_dwait", dwait, 2'b01);
    check("pri_rd_iwait", iwait, 2'b11);
    cyc();
    cyc();
    dREN = 2'b00;
    #1 check("pri_idle_iwait", iwait, 2'b11);
    cyc();
    #1;
    check("if_ramREN", ramREN, 1'b1);
    check("if_ramaddr", ramaddr, 32'h500);
    check("if_iwait", iwait, 2'b10);
    check("if_iload0", iload[0], 32'h3333);
    check("if_dwait", dwait, 2'b11);
    cyc();
    iREN = 2'b00;

    // Requester drops mid-read: no wait released even with ACCESS
    dREN = 2'b01; daddr[0] = 32'h700; ramstate = BUSY;
    cyc();
    #1;
    check("ab_ramREN", ramREN, 1'b1);
    check("ab_dwait_busy", dwait, 2'b11);
    dREN = 2'b00; ramstate = ACCESS;
    #1 check("ab_drop_dwait", dwait, 2'b11);
    cyc();
    #1 check("ab_idle_ramREN", ramREN, 1'b0);

    // Reset asserted while in C2C1
    dREN = 2'b01; cctrans = 2'b11; daddr[0] = 32'h800; daddr[1] = 32'h900;
    dstore[1] = 32'hCAFE; ramstate = BUSY;
    cyc();
    cyc();
    #1;
    check("pre_rst_ramWEN", ramWEN, 1'b1);
    check("pre_rst_ccwait", ccwait, 2'b10);
    nRST = 1'b0;
    #1;
    check("mid_rst_ccwait", ccwait, 2'b00);
    check("mid_rst_dwait", dwait, 2'b11);
    check("mid_rst_iwait", iwait, 2'b11);
    check("mid_rst_ramWEN", ramWEN, 1'b0);
    check("mid_rst_ramREN", ramREN, 1'b0);
    cyc();
    #1 check("held_rst_ramWEN", ramWEN, 1'b0);
    dREN = 2'b11; cctrans = 2'b00; daddr[0] = 32'hA0; daddr[1] = 32'hB0;
    ramstate = ACCESS; nRST = 1'b1;
    cyc();
    #1;
    check("post_rst_ptr_ramaddr", ramaddr, 32'hA0);
    check("post_rst_dwait", dwait, 2'b10);
    cyc();
    cyc();
    dREN = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
